ita_serial_recip_div: RTL and testbench

ITA_SERIAL_RECIP_DIV -- requirements
Module: ita_serial_recip_div

---
 rtl/ita_serial_recip_div.sv | 134 +++++++++++++
 tb/tb_ita_serial_recip_div.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ita_serial_recip_div.sv
// Serial reciprocal divider: quotient = min(floor(2^DividendLog2 / divisor), 2^OutWidth-1),
// computed by one radix-2 restoring step per cycle behind a valid/ready handshake.
module ita_serial_recip_div #(
    parameter int InWidth      = 32,
    parameter int OutWidth     = 32,
    parameter int DividendLog2 = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [InWidth-1:0]  divisor_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OutWidth-1:0] quotient_o,
    output logic                busy_o
);

    localparam int CntW       = $clog2(DividendLog2 + 2);
    localparam int OvfStepsI  = (DividendLog2 >= OutWidth) ? (DividendLog2 - OutWidth + 1) : 0;
    // Steps whose quotient bit lands at or above position OutWidth.
    localparam logic [CntW-1:0] OvfSteps = CntW'(OvfStepsI);
    localparam logic [CntW-1:0] LastStep = CntW'(DividendLog2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [InWidth-1:0]    div_q, div_d;
    logic [InWidth:0]      rem_q, rem_d;
    logic [OutWidth-1:0]   quo_q, quo_d;
    logic [OutWidth-1:0]   res_q, res_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [InWidth+1:0]    rem_wide;
    logic                  q_bit;
    logic                  ovf_bit;

    // Restoring step datapath and FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        // The dividend 2^DividendLog2 has a single 1, consumed on the first step.
        rem_wide = {rem_q, (cnt_q == {CntW{1'b0}})};
        q_bit    = (rem_wide >= {2'b00, div_q});
        ovf_bit  = q_bit && (cnt_q < OvfSteps);

        if (clear_i) begin
            state_d = IDLE;
            res_d   = {OutWidth{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        div_d   = divisor_i;
                        rem_d   = {(InWidth+1){1'b0}};
                        quo_d   = {OutWidth{1'b0}};
                        cnt_d   = {CntW{1'b0}};
                        ovf_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (div_q == {InWidth{1'b0}}) begin
                        res_d   = {OutWidth{1'b1}};
                        state_d = DONE;
                    end else begin
                        rem_d = (InWidth+1)'(q_bit ? (rem_wide - {2'b00, div_q}) : rem_wide);
                        quo_d = OutWidth'({quo_q, q_bit});
                        ovf_d = ovf_q | ovf_bit;
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == LastStep) begin
                            res_d   = (ovf_q | ovf_bit) ? {OutWidth{1'b1}} : OutWidth'({quo_q, q_bit});
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        res_d   = {OutWidth{1'b0}};
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    res_d   = {OutWidth{1'b0}};
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= {InWidth{1'b0}};
            rem_q   <= {(InWidth+1){1'b0}};
            quo_q   <= {OutWidth{1'b0}};
            res_q   <= {OutWidth{1'b0}};
            cnt_q   <= {CntW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    // res_q is cleared on every exit from DONE, so it reads zero whenever out_valid_o is low.
    assign quotient_o  = res_q;

endmodule

// File: tb/tb_ita_serial_recip_div.sv
// Directed and randomised bench for ita_serial_recip_div with an arithmetic reference model.
module tb_ita_serial_recip_div;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] divisor_i = 32'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] quotient_o;
    logic        busy_o;

    int          n_checks = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] exp_val = 32'd0;

    ita_serial_recip_div #(.InWidth(32), .OutWidth(32), .DividendLog2(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .divisor_i(divisor_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .quotient_o(quotient_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model(input logic [31:0] d);
        logic [63:0] q;
        if (d == 32'd0) return 32'hFFFF_FFFF;
        q = 64'h1_0000_0000 / {32'd0, d};
        return (q > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model expectation.
    always @(negedge clk_i) begin
        if (mon_en) begin
            check("mon_busy", {63'd0, busy_o}, {63'd0, ~in_ready_o});
            if (!pending) check("mon_spurious_valid", {63'd0, out_valid_o}, 64'd0);
            if (!out_valid_o) check("mon_q_zero", {32'd0, quotient_o}, 64'd0);
            else check("mon_q_model", {32'd0, quotient_o}, {32'd0, exp_val});
        end
    end

    task automatic start(input logic [31:0] d);
        int waited;
        waited = 0;
        while (!in_ready_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 100) check("start_timeout", 64'd1, 64'd0);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b1;
        divisor_i  = d;
        @(posedge clk_i);
        exp_val = model(d);
        pending = 1'b1;
        #1;
        in_valid_i = 1'b0;
    endtask

    // Wait for the result, optionally stall the consumer, then complete the handshake.
    task automatic finish(input int hold, input logic poke, output logic [31:0] q, output int lat);
        lat = 0;
        q   = 32'd0;
        out_ready_i = (hold == 0);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (out_valid_o) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            check("result_timeout", 64'd1, 64'd0);
            out_ready_i = 1'b0;
            return;
        end
        q = quotient_o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_i);
            #1;
            if (poke) begin
                in_valid_i = 1'b1;
                divisor_i  = 32'd9;
            end
            @(negedge clk_i);
            check("hold_q_stable", {32'd0, quotient_o}, {32'd0, q});
            check("hold_valid", {63'd0, out_valid_o}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready_o}, 64'd0);
        end
        if (hold != 0) begin
            @(posedge clk_i);
            #1;
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
        end
        @(posedge clk_i);
        pending = 1'b0;
        #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        check("post_hs_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("post_hs_valid", {63'd0, out_valid_o}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid_o}, 64'd0);
        check({tag, "_quotient"}, {32'd0, quotient_o}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] d;
        int          lat;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;

        start(32'd2);
        finish(0, 1'b0, q, lat);
        check("div2_q", {32'd0, q}, 64'h8000_0000);
        check("div2_latency", lat, 64'd33);

        start(32'd3);          finish(0, 1'b0, q, lat); check("div3_q", {32'd0, q}, 64'h5555_5555);
        start(32'h0001_0000);  finish(1, 1'b0, q, lat); check("div64k_q", {32'd0, q}, 64'h0001_0000);
        start(32'hFFFF_FFFF);  finish(0, 1'b0, q, lat); check("divmax_q", {32'd0, q}, 64'h0000_0001);
        start(32'd1);          finish(0, 1'b0, q, lat); check("div1_sat", {32'd0, q}, 64'hFFFF_FFFF);
        start(32'd0);          finish(0, 1'b0, q, lat);
        check("div0_q", {32'd0, q}, 64'hFFFF_FFFF);
        check("div0_latency", lat, 64'd1);

        // Consumer stalls 10 cycles while new divisors are offered.
        start(32'd7);
        finish(10, 1'b1, q, lat);
        check("stall_q", {32'd0, q}, 64'h2492_4924);

        // Abort mid-computation.
        start(32'd2);
        repeat (9) @(posedge clk_i);
        #1 clear_i = 1'b1;
        @(posedge clk_i);
        pending = 1'b0;
        #1 clear_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("clear");
        repeat (40) @(negedge clk_i);
        start(32'd4); finish(0, 1'b0, q, lat); check("after_clear_q", {32'd0, q}, 64'h4000_0000);

        // Reset mid-computation.
        start(32'd5);
        repeat (7) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        pending = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("rst_calc");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // Reset and clear together while the result waits in DONE.
        start(32'd6);
        repeat (40) @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        clear_i = 1'b1;
        @(posedge clk_i);
        pending = 1'b0;
        #1;
        rst_i   = 1'b0;
        clear_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("rst_clear");

        for (int i = 0; i < 10; i++) begin
            d = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            start(d);
            finish($urandom_range(0, 2), 1'b0, q, lat);
            check("rand_q", {32'd0, q}, {32'd0, model(d)});
            check("rand_latency", lat, (d == 32'd0) ? 64'd1 : 64'd33);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
